// File: rtl/pc_pkg.sv
// Shared constants and the next-PC source encoding for the fetch-stage PC sequencer.
package pc_pkg;

    localparam int unsigned PC_WIDTH          = 32;
    localparam int unsigned PC_INC            = 4;
    localparam int unsigned PC_RAS_DEPTH      = 4;
    localparam logic [31:0] PC_RESET_VECTOR   = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR     = 32'h0000_0080;

    // Next-PC source, listed in decreasing priority.
    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_EXC,
        SRC_REDIR,
        SRC_HOLD,
        SRC_RAS,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: push, pop and replace-top, with saturating entry count.
module return_addr_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned DEPTH = PC_RAS_DEPTH
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       replace,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_inc;

    // ptr addresses the current top entry; a push writes one slot above it,
    // so a full stack silently overwrites its oldest entry.
    assign ptr_inc = ptr + PW'(1);
    assign top     = mem[ptr];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr_inc;
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end else if (pop && (count != '0)) begin
            ptr   <= ptr - PW'(1);
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (push) begin
                mem[ptr_inc] <= wr_data;
            end else if (replace) begin
                mem[ptr] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: fixed-priority next-PC selection with return-address prediction.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH        = PC_WIDTH,
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = PC_EXC_VECTOR,
    parameter int unsigned INC          = PC_INC,
    parameter int unsigned RAS_DEPTH    = PC_RAS_DEPTH
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Stall,
    input  logic                          Exception,
    input  logic                          Redirect,
    input  logic [WIDTH-1:0]              RedirectAddr,
    input  logic                          Call,
    input  logic                          Ret,
    output logic [WIDTH-1:0]              PCResult,
    output logic [WIDTH-1:0]              PCPlusInc,
    output logic [$clog2(RAS_DEPTH):0]    RasCount,
    output logic                          RetMiss
);

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_VECTOR);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;
    logic             ret_miss_q;
    logic             miss_next;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_replace;
    pc_src_e          src;

    assign PCResult  = pc_q;
    assign PCPlusInc = pc_q + WIDTH'(INC);
    assign RetMiss   = ret_miss_q;

    // Redirect outranks Stall so a resolved branch is never lost behind a
    // stall; only the un-overridden Ret/Call path touches the stack.
    always_comb begin
        src         = SRC_SEQ;
        miss_next   = 1'b0;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_replace = 1'b0;
        if (Reset) begin
            src = SRC_RESET;
        end else if (Exception) begin
            src = SRC_EXC;
        end else if (Redirect) begin
            src = SRC_REDIR;
        end else if (Stall) begin
            src = SRC_HOLD;
        end else if (Ret) begin
            if (RasCount != '0) begin
                src         = SRC_RAS;
                ras_replace = Call;
                ras_pop     = !Call;
            end else begin
                miss_next = 1'b1;
                ras_push  = Call;
            end
        end else begin
            ras_push = Call;
        end
    end

    always_comb begin
        pc_next = PCPlusInc;
        case (src)
            SRC_RESET: pc_next = RESET_PC;
            SRC_EXC:   pc_next = EXC_PC;
            SRC_REDIR: pc_next = RedirectAddr;
            SRC_HOLD:  pc_next = pc_q;
            SRC_RAS:   pc_next = ras_top;
            default:   pc_next = PCPlusInc;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q       <= RESET_PC;
            ret_miss_q <= 1'b0;
        end else begin
            pc_q       <= pc_next;
            ret_miss_q <= miss_next;
        end
    end

    return_addr_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk     (Clk),
        .Reset   (Reset),
        .push    (ras_push),
        .pop     (ras_pop),
        .replace (ras_replace),
        .wr_data (PCPlusInc),
        .top     (ras_top),
        .count   (RasCount)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned D   = 4;
    localparam logic [31:0] INCV = 32'd4;
    localparam logic [31:0] EXCV = 32'h0000_0080;
    localparam logic [31:0] RSTV = 32'h0000_0000;

    logic         Clk;
    logic         Reset;
    logic         Stall;
    logic         Exception;
    logic         Redirect;
    logic [W-1:0] RedirectAddr;
    logic         Call;
    logic         Ret;
    logic [W-1:0] PCResult;
    logic [W-1:0] PCPlusInc;
    logic [2:0]   RasCount;
    logic         RetMiss;

    pc_sequencer #(
        .WIDTH        (W),
        .RESET_VECTOR (RSTV),
        .EXC_VECTOR   (EXCV),
        .INC          (4),
        .RAS_DEPTH    (D)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .Exception    (Exception),
        .Redirect     (Redirect),
        .RedirectAddr (RedirectAddr),
        .Call         (Call),
        .Ret          (Ret),
        .PCResult     (PCResult),
        .PCPlusInc    (PCPlusInc),
        .RasCount     (RasCount),
        .RetMiss      (RetMiss)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Reference model: PC value, miss flag, and the return stack as a queue
    // (back = most recent call, bounded at D entries by dropping the oldest).
    logic [31:0] m_pc;
    logic        m_miss;
    logic [31:0] ras_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_push(input logic [31:0] a);
        if (ras_q.size() == D) void'(ras_q.pop_front());
        ras_q.push_back(a);
    endtask

    task automatic step(input logic rst, input logic stall, input logic exc, input logic redir,
                        input logic [31:0] addr, input logic call, input logic ret);
        logic [31:0] seq;
        logic [31:0] tgt;
        Reset = rst; Stall = stall; Exception = exc; Redirect = redir;
        RedirectAddr = addr; Call = call; Ret = ret;
        seq = m_pc + INCV;
        m_miss = 1'b0;
        if (rst) begin
            m_pc = RSTV;
            ras_q.delete();
        end else if (exc) begin
            m_pc = EXCV;
        end else if (redir) begin
            m_pc = addr;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret && ras_q.size() > 0) begin
            tgt = ras_q[ras_q.size()-1];
            if (call) ras_q[ras_q.size()-1] = seq;
            else void'(ras_q.pop_back());
            m_pc = tgt;
        end else begin
            if (ret) m_miss = 1'b1;
            if (call) model_push(seq);
            m_pc = seq;
        end
        @(posedge Clk);
        #1;
        check("pc", PCResult, m_pc);
        check("pc_plus_inc", PCPlusInc, m_pc + INCV);
        check("ras_count", {29'b0, RasCount}, ras_q.size());
        check("ret_miss", {31'b0, RetMiss}, {31'b0, m_miss});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, 0, 0);
    endtask

    task automatic jump(input logic [31:0] a);
        step(0, 0, 0, 1, a, 0, 0);
    endtask

    logic [31:0] exp_ret [5];
    logic [31:0] raddr;

    initial begin
        m_pc = 32'h0; m_miss = 1'b0;
        Reset = 1'b1; Stall = 1'b0; Exception = 1'b0; Redirect = 1'b0;
        RedirectAddr = '0; Call = 1'b0; Ret = 1'b0;

        // Reset then free-running increments
        step(1, 0, 0, 0, 32'h0, 0, 0);
        check("reset_pc", PCResult, 32'h0);
        check("reset_cnt", {29'b0, RasCount}, 32'd0);
        idle(); check("free1", PCResult, 32'h4);
        idle(); check("free2", PCResult, 32'h8);
        idle(); check("free3", PCResult, 32'hC);

        // Call / return pair
        jump(32'h10);
        step(0, 0, 0, 0, 32'h0, 1, 0); check("call_pc", PCResult, 32'h14);
        check("call_cnt", {29'b0, RasCount}, 32'd1);
        idle(); idle(); check("seq_pc", PCResult, 32'h1C);
        step(0, 0, 0, 0, 32'h0, 0, 1); check("ret_pc", PCResult, 32'h14);
        check("ret_cnt", {29'b0, RasCount}, 32'd0);

        // Stall holds and blocks pushes; Redirect overrides Stall
        jump(32'h40);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 1, 0);
        check("stall_pc", PCResult, 32'h40);
        check("stall_cnt", {29'b0, RasCount}, 32'd0);
        step(0, 1, 0, 1, 32'h200, 0, 0); check("redir_stall", PCResult, 32'h200);

        // Overflowing the stack, then draining it past empty
        step(1, 0, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 32'h0, 1, 0);
        check("full_cnt", {29'b0, RasCount}, 32'd4);
        exp_ret[0] = 32'h14; exp_ret[1] = 32'h10; exp_ret[2] = 32'hC;
        exp_ret[3] = 32'h8;  exp_ret[4] = 32'hC;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 32'h0, 0, 1);
            check("drain_pc", PCResult, exp_ret[i]);
            check("drain_miss", {31'b0, RetMiss}, (i == 4) ? 32'd1 : 32'd0);
        end
        idle(); check("miss_pulse", {31'b0, RetMiss}, 32'd0);

        // Exception wins over Redirect and Ret; Reset wins over Call
        step(0, 0, 0, 0, 32'h0, 1, 0);
        step(0, 0, 1, 1, 32'h300, 0, 1); check("exc_pc", PCResult, 32'h80);
        check("exc_cnt", {29'b0, RasCount}, 32'd1);
        step(1, 0, 0, 0, 32'h0, 1, 0); check("rst_call_pc", PCResult, 32'h0);
        check("rst_call_cnt", {29'b0, RasCount}, 32'd0);

        // Address wrap and tail call
        jump(32'hFFFF_FFFC);
        idle(); check("wrap_pc", PCResult, 32'h0);
        jump(32'hFC);
        step(0, 0, 0, 0, 32'h0, 1, 0);
        jump(32'h20);
        step(0, 0, 0, 0, 32'h0, 1, 1); check("tail_pc", PCResult, 32'h100);
        check("tail_cnt", {29'b0, RasCount}, 32'd1);
        jump(32'h500);
        step(0, 0, 0, 0, 32'h0, 0, 1); check("tail_top", PCResult, 32'h24);

        // Tail call on an empty stack
        step(0, 0, 0, 0, 32'h0, 1, 1);
        check("tail_empty_miss", {31'b0, RetMiss}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            raddr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                 raddr, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
